// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_arbiter_pkg
// Purpose : Shared constants for the instruction-memory arbiter: default
//           legal address window, FSM state encodings, owner encodings and
//           the address legality helper.
// Rev     : 1.0  initial release
// ============================================================================
package imem_arbiter_pkg;

   // Default legal window of the instruction memory (byte addresses)
   localparam logic [31:0] IMEM_BASE = 32'h0100_0000;
   localparam logic [31:0] IMEM_LAST = 32'h0100_09FC;

   // Arbiter FSM states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   // Response owner encoding
   localparam logic OWN_F = 1'b0;
   localparam logic OWN_D = 1'b1;

   // Word aligned and inside [base, last], unsigned compare
   function automatic logic addr_legal(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] last);
      return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= last);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-way arbiter producing a one-hot grant. With RR_EN set the
//           priority pointer moves to the other port after every grant;
//           otherwise port 0 always wins.
// Rev     : 1.0  initial release
// ============================================================================
module rr_arb2 #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // ptr = 1 means port 1 has priority when both request
   logic ptr;
   logic prio;

   assign prio = (RR_EN) ? ptr : 1'b0;

   // One-hot grant selection from the current requests and priority
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // Pointer moves to the port that did not win
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (advance && (grant != 2'b00)) begin
         ptr <= grant[0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : imem_arbiter
// Purpose : Shares a single-port synchronous-read instruction memory between
//           the fetch port (F) and the debug/loader port (D). One read in
//           flight, one word per cycle, illegal addresses answered with an
//           error response and no memory access.
// Rev     : 1.0  initial release
// ============================================================================
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = IMEM_BASE,
   parameter logic [31:0] ADDR_LAST = IMEM_LAST,
   parameter bit          RR_EN     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   // fetch port
   input  logic        f_req_valid,
   input  logic [31:0] f_req_addr,
   output logic        f_req_ready,
   output logic        f_resp_valid,
   input  logic        f_resp_ready,
   output logic [31:0] f_resp_data,
   output logic        f_resp_err,
   // debug port
   input  logic        d_req_valid,
   input  logic [31:0] d_req_addr,
   output logic        d_req_ready,
   output logic        d_resp_valid,
   input  logic        d_resp_ready,
   output logic [31:0] d_resp_data,
   output logic        d_resp_err,
   // memory
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_instr
);

   logic [0:0]  state;
   logic        owner;
   logic        err_flag;

   logic        resp_accept;
   logic        can_grant;
   logic [1:0]  arb_req;
   logic [1:0]  grant;
   logic        granted;
   logic [31:0] win_addr;
   logic        win_legal;

   // A slot opens when idle, or when the pending response leaves this cycle
   assign resp_accept = (state == ST_RESP) &&
                        ((owner == OWN_D) ? d_resp_ready : f_resp_ready);
   assign can_grant   = !rst && ((state == ST_IDLE) || resp_accept);
   assign arb_req     = {d_req_valid, f_req_valid} & {2{can_grant}};
   assign granted     = (grant != 2'b00);

   rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (arb_req),
      .advance (can_grant),
      .grant   (grant)
   );

   assign win_addr  = grant[1] ? d_req_addr : f_req_addr;
   assign win_legal = addr_legal(win_addr, ADDR_BASE, ADDR_LAST);

   assign f_req_ready = grant[0];
   assign d_req_ready = grant[1];
   assign mem_rd      = granted && win_legal;
   assign mem_addr    = granted ? win_addr : 32'h0;

   // Response outputs come straight from registered state and the memory
   // output register, which holds because no read is issued while waiting
   assign f_resp_valid = (state == ST_RESP) && (owner == OWN_F);
   assign d_resp_valid = (state == ST_RESP) && (owner == OWN_D);
   assign f_resp_err   = f_resp_valid && err_flag;
   assign d_resp_err   = d_resp_valid && err_flag;
   assign f_resp_data  = (f_resp_valid && !err_flag) ? mem_instr : 32'h0;
   assign d_resp_data  = (d_resp_valid && !err_flag) ? mem_instr : 32'h0;

   // FSM: new grant loads owner/error; accepted response without grant idles
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         owner    <= OWN_F;
         err_flag <= 1'b0;
      end else if (granted) begin
         state    <= ST_RESP;
         owner    <= grant[1] ? OWN_D : OWN_F;
         err_flag <= !win_legal;
      end else if (resp_accept) begin
         state    <= ST_IDLE;
         err_flag <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_arbiter
// Purpose : Directed self-checking bench for imem_arbiter (round-robin and
//           fixed-priority instances driven by the same stimulus).
// Rev     : 1.0  initial release
// ============================================================================
module tb_imem_arbiter;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req_valid, d_req_valid;
   logic [31:0] f_req_addr, d_req_addr;
   logic        f_resp_ready, d_resp_ready;

   // round-robin instance outputs
   logic        f_req_ready, f_resp_valid, f_resp_err;
   logic        d_req_ready, d_resp_valid, d_resp_err;
   logic [31:0] f_resp_data, d_resp_data, mem_addr, mem_instr;
   logic        mem_rd;

   // fixed-priority instance outputs
   logic        fp_f_req_ready, fp_f_resp_valid, fp_f_resp_err;
   logic        fp_d_req_ready, fp_d_resp_valid, fp_d_resp_err;
   logic [31:0] fp_f_resp_data, fp_d_resp_data, fp_mem_addr, fp_mem_instr;
   logic        fp_mem_rd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Memory contents: a recognisable pattern derived from the address
   function automatic logic [31:0] word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
   endfunction

   // Synchronous-read memory models, output holds when not reading
   always @(posedge clk) if (mem_rd)    mem_instr    <= word(mem_addr);
   always @(posedge clk) if (fp_mem_rd) fp_mem_instr <= word(fp_mem_addr);

   imem_arbiter #(.RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
      .f_resp_valid(f_resp_valid), .f_resp_ready(f_resp_ready),
      .f_resp_data(f_resp_data), .f_resp_err(f_resp_err),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
      .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_instr(mem_instr)
   );

   imem_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(fp_f_req_ready),
      .f_resp_valid(fp_f_resp_valid), .f_resp_ready(f_resp_ready),
      .f_resp_data(fp_f_resp_data), .f_resp_err(fp_f_resp_err),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(fp_d_req_ready),
      .d_resp_valid(fp_d_resp_valid), .d_resp_ready(d_resp_ready),
      .d_resp_data(fp_d_resp_data), .d_resp_err(fp_d_resp_err),
      .mem_rd(fp_mem_rd), .mem_addr(fp_mem_addr), .mem_instr(fp_mem_instr)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next drive point (falling edge), checks follow at #1
   task automatic next_cycle;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [31:0] ill_addr [4];
   logic        ill_err  [4];

   initial begin
      rst = 1'b1;
      f_req_valid = 1'b0; d_req_valid = 1'b0;
      f_req_addr = 32'h0; d_req_addr = 32'h0;
      f_resp_ready = 1'b1; d_resp_ready = 1'b1;
      ill_addr[0] = 32'h0100_0002; ill_err[0] = 1'b1;
      ill_addr[1] = 32'h0100_0A00; ill_err[1] = 1'b1;
      ill_addr[2] = 32'h00FF_FFFC; ill_err[2] = 1'b1;
      ill_addr[3] = 32'h0100_09FC; ill_err[3] = 1'b0;

      // ---- reset held: no grants even with both requesting
      next_cycle(); next_cycle();
      f_req_valid = 1'b1; d_req_valid = 1'b1;
      f_req_addr = BASE; d_req_addr = BASE;
      #1;
      check_eq("rst_f_req_ready", f_req_ready, 0);
      check_eq("rst_d_req_ready", d_req_ready, 0);
      check_eq("rst_mem_rd", mem_rd, 0);
      next_cycle();
      rst = 1'b0; f_req_valid = 1'b0; d_req_valid = 1'b0;
      #1;
      check_eq("rst_f_resp_valid", f_resp_valid, 0);
      check_eq("rst_d_resp_valid", d_resp_valid, 0);
      check_eq("rst_mem_addr", mem_addr, 0);

      // ---- 1: F-only stream of three words
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         f_req_valid = (k < 3);
         f_req_addr  = BASE + 32'(4 * k);
         #1;
         check_eq("s1_f_req_ready", f_req_ready, (k < 3) ? 1 : 0);
         check_eq("s1_mem_rd", mem_rd, (k < 3) ? 1 : 0);
         if (k < 3) check_eq("s1_mem_addr", mem_addr, BASE + 32'(4 * k));
         check_eq("s1_f_resp_valid", f_resp_valid, (k > 0) ? 1 : 0);
         if (k > 0) check_eq("s1_f_resp_data", f_resp_data, word(BASE + 32'(4 * (k - 1))));
      end
      next_cycle(); #1;
      check_eq("s1_idle", f_resp_valid, 0);

      // ---- 2: contention, pointer starts at F after a reset
      next_cycle(); rst = 1'b1;
      next_cycle(); rst = 1'b0;
      f_req_valid = 1'b1; d_req_valid = 1'b1;
      f_req_addr = BASE + 32'h40; d_req_addr = BASE + 32'h100;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("s2_rr_f_ready", f_req_ready, (k % 2 == 0) ? 1 : 0);
         check_eq("s2_rr_d_ready", d_req_ready, (k % 2 == 1) ? 1 : 0);
         check_eq("s2_fp_f_ready", fp_f_req_ready, 1);
         check_eq("s2_fp_d_ready", fp_d_req_ready, 0);
         if (k > 0) begin
            check_eq("s2_rr_d_resp_valid", d_resp_valid, (k % 2 == 0) ? 1 : 0);
            check_eq("s2_fp_f_resp_data", fp_f_resp_data, word(BASE + 32'h40));
         end
         next_cycle();
      end
      f_req_valid = 1'b0; d_req_valid = 1'b0;
      #1;
      check_eq("s2_rr_last_d_valid", d_resp_valid, 1);
      check_eq("s2_rr_last_d_data", d_resp_data, word(BASE + 32'h100));
      check_eq("s2_fp_d_resp_valid", fp_d_resp_valid, 0);

      // ---- 3: backpressure on F
      next_cycle();
      f_resp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = BASE + 32'h10;
      #1;
      check_eq("s3_grant", f_req_ready, 1);
      next_cycle();
      f_req_addr = BASE + 32'h14;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_eq("s3_stall_valid", f_resp_valid, 1);
         check_eq("s3_stall_data", f_resp_data, word(BASE + 32'h10));
         check_eq("s3_stall_mem_rd", mem_rd, 0);
         check_eq("s3_stall_req_ready", f_req_ready, 0);
         next_cycle();
      end
      f_resp_ready = 1'b1;
      #1;
      check_eq("s3_release_ready", f_req_ready, 1);
      check_eq("s3_release_mem_rd", mem_rd, 1);
      check_eq("s3_release_addr", mem_addr, BASE + 32'h14);
      check_eq("s3_release_data", f_resp_data, word(BASE + 32'h10));
      next_cycle();
      f_req_valid = 1'b0;
      #1;
      check_eq("s3_next_data", f_resp_data, word(BASE + 32'h14));

      // ---- 4: illegal and boundary addresses on D, back-to-back
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         d_req_valid = (k < 4);
         if (k < 4) d_req_addr = ill_addr[k];
         #1;
         if (k < 4) begin
            check_eq("s4_d_req_ready", d_req_ready, 1);
            check_eq("s4_mem_rd", mem_rd, ill_err[k] ? 0 : 1);
         end
         if (k > 0) begin
            check_eq("s4_d_resp_valid", d_resp_valid, 1);
            check_eq("s4_d_resp_err", d_resp_err, ill_err[k - 1]);
            check_eq("s4_d_resp_data", d_resp_data,
                     ill_err[k - 1] ? 32'h0 : word(ill_addr[k - 1]));
         end
      end

      // ---- 5: reset right after a grant discards the read
      next_cycle();
      f_resp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = BASE + 32'h20;
      #1;
      check_eq("s5_grant", f_req_ready, 1);
      next_cycle();
      f_req_valid = 1'b0; rst = 1'b1;
      next_cycle();
      rst = 1'b0; f_resp_ready = 1'b1;
      #1;
      check_eq("s5_f_resp_valid", f_resp_valid, 0);
      check_eq("s5_f_resp_data", f_resp_data, 0);
      check_eq("s5_f_resp_err", f_resp_err, 0);
      check_eq("s5_mem_rd", mem_rd, 0);
      check_eq("s5_mem_addr", mem_addr, 0);
      check_eq("s5_f_req_ready", f_req_ready, 0);
      next_cycle();
      f_req_valid = 1'b1; d_req_valid = 1'b1;
      f_req_addr = BASE + 32'h30; d_req_addr = BASE + 32'h34;
      #1;
      check_eq("s5_first_f", f_req_ready, 1);
      check_eq("s5_first_d", d_req_ready, 0);
      next_cycle();
      f_req_valid = 1'b0; d_req_valid = 1'b0;
      #1;
      check_eq("s5_resp_data", f_resp_data, word(BASE + 32'h30));
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
